// File: rtl/multiboot_request_if.sv
// Host register bus and boot-request signals for multiboot_request.
//   reg_wr/reg_sel/reg_din : byte write port from the host register bank
//   reg_dout               : combinational readback selected by reg_sel
//   btn_n                  : front-panel button, active-low, asynchronous
//   mbt_reboot             : one-cycle reboot request to the ICAP sequencer
//   spi_addr               : frozen flash boot address, stable while busy
//   busy                   : request in flight / hold-off active
// slave modport is the multiboot_request view; master is the driver view.
interface multiboot_request_if;
    logic        reg_wr;
    logic [1:0]  reg_sel;
    logic [7:0]  reg_din;
    logic [7:0]  reg_dout;
    logic        btn_n;
    logic        mbt_reboot;
    logic [23:0] spi_addr;
    logic        busy;

    modport slave (
        input  reg_wr, reg_sel, reg_din, btn_n,
        output reg_dout, mbt_reboot, spi_addr, busy
    );

    modport master (
        output reg_wr, reg_sel, reg_din, btn_n,
        input  reg_dout, mbt_reboot, spi_addr, busy
    );
endinterface

// File: rtl/multiboot_request.sv
// multiboot_request: stages a 24-bit SPI flash boot address from host byte
// writes and, on a keyed CTRL write, freezes it and issues a single-cycle
// reboot request to the ICAP multiboot sequencer, then stays busy for
// HOLDOFF cycles so the sequence can complete.
// Ports:
//   clk   : ICAP clock (<= 20 MHz)
//   rst_n : asynchronous active-low reset
//   bus   : multiboot_request_if.slave (register port, button, boot outputs)
// Optional feature macro MBT_LONGPRESS_EN: a button held low for
// LONGPRESS_CYCLES (synchronized) triggers a reboot to GOLDEN_ADDR.
module multiboot_request #(
    parameter logic [7:0]  KEY              = 8'hB7,
    parameter int unsigned HOLDOFF          = 32,
    parameter logic [23:0] GOLDEN_ADDR      = 24'h000000,
    parameter int unsigned LONGPRESS_CYCLES = 20000000
) (
    input  logic                clk,
    input  logic                rst_n,
    multiboot_request_if.slave  bus
);

    localparam int unsigned HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_PULSE,
        S_HOLD
    } state_e;

    state_e          state_q, state_d;
    logic [23:0]     staging_q, staging_d;
    logic [23:0]     spi_addr_q, spi_addr_d;
    logic            busy_q, busy_d;
    logic            reboot_q, reboot_d;
    logic            err_q, err_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            lp_fire_c;
    logic            ctrl_wr_c;
    logic            key_trig_c;

    assign ctrl_wr_c  = bus.reg_wr && (bus.reg_sel == 2'd3);
    assign key_trig_c = ctrl_wr_c && (bus.reg_din == KEY) && (state_q == S_IDLE);

`ifdef MBT_LONGPRESS_EN
    localparam int unsigned LW = $clog2(LONGPRESS_CYCLES + 1);

    logic [1:0]    btn_sync_q;
    logic [LW-1:0] lp_cnt_q;
    logic          lp_done_q;
    logic          lp_hit_c;

    // Synchronizer plus saturating hold counter; lp_done_q blocks re-fire until release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync_q <= 2'b11;
            lp_cnt_q   <= '0;
            lp_done_q  <= 1'b0;
        end else begin
            btn_sync_q <= {btn_sync_q[0], bus.btn_n};
            if (btn_sync_q[1]) begin
                lp_cnt_q  <= '0;
                lp_done_q <= 1'b0;
            end else begin
                if (lp_cnt_q != LW'(LONGPRESS_CYCLES)) begin
                    lp_cnt_q <= lp_cnt_q + LW'(1);
                end
                if (lp_hit_c) begin
                    lp_done_q <= 1'b1;
                end
            end
        end
    end

    // A hit while busy still sets lp_done_q, so it is discarded until release.
    assign lp_hit_c  = (lp_cnt_q == LW'(LONGPRESS_CYCLES)) && !lp_done_q;
    assign lp_fire_c = lp_hit_c && (state_q == S_IDLE);
`else
    logic unused_lp;

    assign lp_fire_c = 1'b0;
    assign unused_lp = ^{bus.btn_n, GOLDEN_ADDR, 32'(LONGPRESS_CYCLES)};
`endif

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            staging_q  <= '0;
            spi_addr_q <= '0;
            busy_q     <= 1'b0;
            reboot_q   <= 1'b0;
            err_q      <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            staging_q  <= staging_d;
            spi_addr_q <= spi_addr_d;
            busy_q     <= busy_d;
            reboot_q   <= reboot_d;
            err_q      <= err_d;
            hold_q     <= hold_d;
        end
    end

    // Register writes and request sequencing.
    always_comb begin
        state_d    = state_q;
        staging_d  = staging_q;
        spi_addr_d = spi_addr_q;
        busy_d     = busy_q;
        reboot_d   = 1'b0;
        err_d      = err_q;
        hold_d     = hold_q;

        if (bus.reg_wr) begin
            case (bus.reg_sel)
                2'd0: staging_d[7:0]   = bus.reg_din;
                2'd1: staging_d[15:8]  = bus.reg_din;
                2'd2: staging_d[23:16] = bus.reg_din;
                default: begin
                    // KEY is handled by the FSM (and silently ignored while busy).
                    if (bus.reg_din == 8'h00) begin
                        err_d = 1'b0;
                    end else if (bus.reg_din != KEY) begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end

        case (state_q)
            S_IDLE: begin
                // Long-press has priority over a coincident KEY write.
                if (lp_fire_c) begin
                    state_d    = S_ARM;
                    spi_addr_d = GOLDEN_ADDR;
                    busy_d     = 1'b1;
                    err_d      = 1'b0;
                end else if (key_trig_c) begin
                    state_d    = S_ARM;
                    spi_addr_d = staging_q;
                    busy_d     = 1'b1;
                    err_d      = 1'b0;
                end
            end
            S_ARM: begin
                state_d  = S_PULSE;
                reboot_d = 1'b1;
            end
            S_PULSE: begin
                state_d = S_HOLD;
                hold_d  = HW'(HOLDOFF - 1);
            end
            S_HOLD: begin
                if (hold_q == '0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Readback mux.
    always_comb begin
        case (bus.reg_sel)
            2'd0:    bus.reg_dout = staging_q[7:0];
            2'd1:    bus.reg_dout = staging_q[15:8];
            2'd2:    bus.reg_dout = staging_q[23:16];
            default: bus.reg_dout = {busy_q, err_q, 5'b0, reboot_q};
        endcase
    end

    assign bus.mbt_reboot = reboot_q;
    assign bus.spi_addr   = spi_addr_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_multiboot_request.sv
// Testbench for multiboot_request: directed scenarios followed by random
// register traffic, all checked every cycle against a timeline model.
module tb_multiboot_request;

    localparam logic [7:0]  KEY     = 8'hB7;
    localparam int          HOLDOFF = 32;
    localparam logic [23:0] GOLDEN  = 24'h000000;
    localparam int          LP      = 100;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    multiboot_request_if bus ();

    multiboot_request #(
        .KEY              (KEY),
        .HOLDOFF          (HOLDOFF),
        .GOLDEN_ADDR      (GOLDEN),
        .LONGPRESS_CYCLES (LP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model: staging bytes, sticky error, address and the edge
    // at which the last request was accepted (busy/pulse follow from it).
    logic [7:0]  stg [3];
    logic [23:0] m_addr;
    logic        m_err;
    int          trig_edge;
    int          lp_start;
    logic        btn_val = 1'b1;
    int          obs_pulses;
    int          obs_busy;

    function automatic bit in_busy(input int k);
        int rel = k - trig_edge;
        return (rel >= 0) && (rel <= HOLDOFF + 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) stg[i] = 8'h00;
        m_addr    = 24'h0;
        m_err     = 1'b0;
        trig_edge = -100000;
        lp_start  = -1;
    endtask

    task automatic model_edge(input bit wr, input logic [1:0] sel, input logic [7:0] din);
        bit idle;
        bit lp_fire;
        idle    = !in_busy(cyc - 1);
        lp_fire = 1'b0;
`ifdef MBT_LONGPRESS_EN
        if (btn_val) begin
            lp_start = -1;
        end else begin
            if (lp_start < 0) lp_start = cyc;
            lp_fire = (cyc == lp_start + LP + 2) && idle;
        end
`endif
        if (wr && sel != 2'd3) stg[sel] = din;
        if (wr && sel == 2'd3 && din != KEY) m_err = (din != 8'h00);
        if (lp_fire) begin
            trig_edge = cyc;
            m_addr    = GOLDEN;
            m_err     = 1'b0;
        end else if (wr && sel == 2'd3 && din == KEY && idle) begin
            trig_edge = cyc;
            m_addr    = {stg[2], stg[1], stg[0]};
            m_err     = 1'b0;
        end
    endtask

    task automatic check_all();
        logic       e_busy;
        logic       e_pulse;
        logic [7:0] e_dout;
        e_busy  = in_busy(cyc);
        e_pulse = (cyc - trig_edge) == 1;
        e_dout  = (bus.reg_sel == 2'd3) ? {e_busy, m_err, 5'b0, e_pulse} : stg[bus.reg_sel];
        chk("mbt_reboot", 32'(bus.mbt_reboot), 32'(e_pulse));
        chk("busy", 32'(bus.busy), 32'(e_busy));
        chk("spi_addr", 32'(bus.spi_addr), 32'(m_addr));
        chk("reg_dout", 32'(bus.reg_dout), 32'(e_dout));
        obs_pulses += int'(bus.mbt_reboot);
        obs_busy   += int'(bus.busy);
    endtask

    task automatic step(input bit wr, input logic [1:0] sel, input logic [7:0] din);
        @(negedge clk);
        bus.reg_wr  = wr;
        bus.reg_sel = sel;
        bus.reg_din = din;
        bus.btn_n   = btn_val;
        @(posedge clk);
        cyc++;
        model_edge(wr, sel, din);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'($urandom_range(0, 3)), 8'($urandom));
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.reg_wr  = 1'b0;
        bus.reg_sel = 2'd3;
        bus.reg_din = 8'h00;
        bus.btn_n   = 1'b1;
        model_reset();
        #12;
        chk("reset_reboot", 32'(bus.mbt_reboot), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_addr", 32'(bus.spi_addr), 32'd0);
        chk("reset_dout", 32'(bus.reg_dout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic reboot: pulse count and busy length.
        step(1'b1, 2'd0, 8'h00);
        step(1'b1, 2'd1, 8'h0A);
        step(1'b1, 2'd2, 8'h05);
        obs_pulses = 0;
        obs_busy   = 0;
        step(1'b1, 2'd3, KEY);
        chk("basic_addr", 32'(bus.spi_addr), 32'h050A00);
        idle(45);
        chk("basic_pulses", 32'(obs_pulses), 32'd1);
        chk("basic_busy_len", 32'(obs_busy), 32'(HOLDOFF + 2));

        // Busy lockout: staging and KEY during HOLD.
        step(1'b1, 2'd3, KEY);
        idle(6);
        obs_pulses = 0;
        step(1'b1, 2'd2, 8'h07);
        step(1'b1, 2'd3, KEY);
        chk("lock_addr", 32'(bus.spi_addr), 32'h050A00);
        idle(40);
        chk("lock_pulses", 32'(obs_pulses), 32'd0);
        step(1'b1, 2'd3, KEY);
        chk("lock_new_addr", 32'(bus.spi_addr), 32'h070A00);
        idle(40);

        // Bad key, clear, then a good trigger.
        step(1'b1, 2'd3, 8'h55);
        chk("badkey_err", 32'(bus.reg_dout[6]), 32'd1);
        step(1'b1, 2'd3, 8'h00);
        chk("clr_err", 32'(bus.reg_dout[6]), 32'd0);
        obs_pulses = 0;
        step(1'b1, 2'd3, KEY);
        idle(40);
        chk("after_clr_pulses", 32'(obs_pulses), 32'd1);

        // Asynchronous reset in the middle of HOLD.
        step(1'b1, 2'd3, KEY);
        idle(10);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midhold_reboot", 32'(bus.mbt_reboot), 32'd0);
        chk("midhold_busy", 32'(bus.busy), 32'd0);
        chk("midhold_addr", 32'(bus.spi_addr), 32'd0);
        chk("midhold_dout", 32'(bus.reg_dout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 2'd1, 8'h3C);
        obs_pulses = 0;
        step(1'b1, 2'd3, KEY);
        chk("post_rst_addr", 32'(bus.spi_addr), 32'h003C00);
        idle(40);
        chk("post_rst_pulses", 32'(obs_pulses), 32'd1);

        // Random register traffic.
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 3)      step(1'b1, 2'($urandom_range(0, 2)), 8'($urandom));
            else if (r <= 5) step(1'b1, 2'd3, KEY);
            else if (r == 6) step(1'b1, 2'd3, 8'h00);
            else if (r == 7) step(1'b1, 2'd3, 8'($urandom));
            else             step(1'b0, 2'($urandom_range(0, 3)), 8'($urandom));
        end
        idle(40);

`ifdef MBT_LONGPRESS_EN
        // Long-press to golden address; one fire per press.
        step(1'b1, 2'd0, 8'h56);
        step(1'b1, 2'd1, 8'h34);
        step(1'b1, 2'd2, 8'h12);
        obs_pulses = 0;
        btn_val    = 1'b0;
        idle(150);
        chk("lp_pulses1", 32'(obs_pulses), 32'd1);
        chk("lp_addr", 32'(bus.spi_addr), 32'(GOLDEN));
        step(1'b0, 2'd2, 8'h00);
        chk("lp_staging_hi", 32'(bus.reg_dout), 32'h12);
        btn_val = 1'b1;
        idle(10);
        btn_val = 1'b0;
        idle(150);
        btn_val = 1'b1;
        idle(5);
        chk("lp_pulses2", 32'(obs_pulses), 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multiboot_request.md
Name: multiboot_request

Overview:
- Upstream feeder for the ICAP multiboot sequencer.
- Accepts byte writes from the host-side register bank and stages a 24-bit SPI flash bitstream address.
- On a keyed command write, freezes that address and emits a single-cycle reboot request, then holds off long enough for the ICAP sequence to complete.
- Runs in the ICAP clock domain (≤20 MHz).

Parameters:
- KEY, 8'hB7, ctrl value that triggers a reboot
- HOLDOFF, 32, cycles busy stays high after the request pulse (≥ sequencer length of 16)
- GOLDEN_ADDR, 24'h000000, flash address used by the long-press path
- LONGPRESS_CYCLES, 20000000, cycles button must be held low (only with MBT_LONGPRESS_EN)

Ports:
- clk  in  1  ICAP clock, ≤20 MHz
- rst_n  in  1  asynchronous active-low reset
- reg_wr  in  1  one-cycle write strobe
- reg_sel  in  2  0=ADDR_LO, 1=ADDR_MID, 2=ADDR_HI, 3=CTRL
- reg_din  in  8  write data
- reg_dout  out  8  readback, combinational mux on reg_sel
- btn_n  in  1  front-panel button, asynchronous, active-low (used only with MBT_LONGPRESS_EN)
- mbt_reboot  out  1  one-cycle reboot request to the sequencer
- spi_addr  out  24  frozen boot address; stable whenever busy=1
- busy  out  1  request in flight / hold-off active

Behaviour:
- Reset (async, rst_n=0):
  - staging=0, spi_addr=0, mbt_reboot=0, busy=0, err=0, state=IDLE, hold-off counter=0.
  - Any operation in progress is abandoned.
- Staging register writes (reg_wr with reg_sel 0..2): update staging[7:0], [15:8] or [23:16] at the clock edge. Accepted in every state.
- Readback:
  - reg_sel 0..2 returns the staging bytes.
  - reg_sel 3 returns {busy, err, 5'b0, mbt_reboot}.
- CTRL write (reg_sel=3):
  - din==KEY and state==IDLE: trigger.
  - din==KEY while busy: ignored, no flag set.
  - din==8'h00: clears err.
  - Any other value: sets err (sticky); no trigger.
- State machine:
  - IDLE -> ARM on trigger. At that edge spi_addr<=staging and busy<=1.
  - ARM -> PULSE. mbt_reboot=1 during the PULSE cycle only, so the pulse is exactly 1 cycle, asserted 2 edges after the accepted write. spi_addr is already stable 1 cycle before the pulse.
  - PULSE -> HOLD. Counter loads HOLDOFF-1.
  - HOLD: decrement the counter each cycle. At 0 -> IDLE with busy<=0.
  - busy is high from the ARM edge through the last HOLD cycle.
- Staging writes during busy do not alter spi_addr.
- A successful trigger clears err.
- Simultaneous staging write and KEY trigger in the same cycle is impossible (single reg_sel), so no arbitration is needed.
- All outputs are registered except reg_dout.

Optional Feature:
- MBT_LONGPRESS_EN defined:
  - btn_n passes through a 2-FF synchronizer.
  - A saturating counter increments while the synchronized btn_n=0 and clears when it is 1.
  - When the counter reaches LONGPRESS_CYCLES in IDLE, trigger with spi_addr<=GOLDEN_ADDR; staging is left untouched.
  - Fires once per press; the button must be released (synchronized high) before it can re-arm.
  - A long-press fire and a KEY write in the same cycle: long-press wins and GOLDEN_ADDR is loaded.
  - A long-press reached while busy is discarded; no retrigger until release.
- MBT_LONGPRESS_EN undefined: btn_n is unused, there is no synchronizer or counter, and only the register path triggers.

Test Plan:
- Reset mid-HOLD: trigger, assert rst_n=0 async mid-HOLD -> all outputs 0 immediately; after release a new KEY trigger works normally.
- Basic reboot: write 0x00/0x0A/0x05 to sel 0/1/2, then 0xB7 to sel 3 -> spi_addr=24'h050A00 one edge later; mbt_reboot high exactly 1 cycle, 2 edges after the write; busy high for 34 cycles total (HOLDOFF=32).
- Busy lockout: during HOLD write ADDR_HI=0x07 and CTRL=0xB7 -> no second pulse, spi_addr unchanged at 050A00, err=0; after busy falls, KEY write yields spi_addr=070A00.
- Bad key: CTRL=0x55 -> no pulse, reg_dout(sel3)[6]=1; CTRL=0x00 -> err=0; a subsequent KEY trigger pulses and err stays 0.
- Long-press (macro on, LONGPRESS_CYCLES=100, staging=0x123456): hold btn_n low for 150 cycles -> exactly one pulse with spi_addr=GOLDEN_ADDR (000000) and staging still 123456; keep holding past hold-off -> no further pulse; release and press again -> fires again.
